// File: rtl/sec_an_decoder_seq.sv
// Sequential single-arithmetic-error-correcting decoder for AN codes.
// A received word W = A*N (+/- 2^i) is reduced mod A bit-serially. A zero
// residue goes straight to division. A non-zero residue triggers a search over
// +/-(2^i mod A) for one error position. The corrected word is then divided by A,
// one bit per cycle, to recover N.
module sec_an_decoder_seq #(
    parameter int                N_BITS = 52,
    parameter int                A_BITS = 9,
    parameter logic [A_BITS-1:0] A      = 9'd311,
    localparam int               W_BITS = N_BITS + A_BITS,
    localparam int               P_BITS = $clog2(W_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] W,
    output logic              found,
    input  logic              out_ready,
    output logic [N_BITS:0]   N,
    output logic [1:0]        status,
    output logic [P_BITS-1:0] err_pos,
    output logic              err_sign
);

    localparam int              C_BITS    = $clog2(W_BITS + 1);
    localparam logic [A_BITS:0] A_X       = {1'b0, A};
    localparam logic [1:0]      ST_CLEAN  = 2'd0;
    localparam logic [1:0]      ST_CORR   = 2'd1;
    localparam logic [1:0]      ST_UNCORR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESID,
        S_SEARCH,
        S_CORR,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                found_q;
    logic [N_BITS:0]     n_q;
    logic [1:0]          status_q;
    logic [P_BITS-1:0]   err_pos_q;
    logic                err_sign_q;

    // Working datapath state (not reset: always loaded before it is used).
    logic [W_BITS:0]     word_q;
    logic [W_BITS:0]     cand_q;
    logic [W_BITS-1:0]   sh_q;
    logic [A_BITS:0]     r_q;
    logic [A_BITS:0]     p_q;
    logic [A_BITS:0]     rem_q;
    logic [C_BITS-1:0]   cnt_q;
    logic [P_BITS-1:0]   idx_q;
    logic                sign_q;

    logic [W_BITS:0]     pow_w;
    logic [W_BITS:0]     sub_w;
    logic [W_BITS:0]     add_w;
    logic                sub_ok;
    logic                add_ok;

    // True when the doubled value plus the incoming bit reaches the modulus.
    function automatic logic ge_a(input logic [A_BITS:0] v, input logic b);
        logic [A_BITS+1:0] t;
        t = {v, b};
        return t >= {1'b0, A_X};
    endfunction

    // One MSB-first reduction step: (2*v + b) mod A, with v < A on entry.
    function automatic logic [A_BITS:0] mod_dbl(input logic [A_BITS:0] v, input logic b);
        logic [A_BITS+1:0] t;
        t = {v, b};
        if (t >= {1'b0, A_X}) begin
            t = t - {1'b0, A_X};
        end
        return t[A_BITS:0];
    endfunction

    // Candidate corrections for the current search index, one bit wider than W.
    // No wrap-around is possible at this width.
    assign pow_w  = {{W_BITS{1'b0}}, 1'b1} << idx_q;
    assign sub_w  = word_q - pow_w;
    assign add_w  = word_q + pow_w;
    assign sub_ok = (word_q >= pow_w);
    assign add_ok = ~add_w[W_BITS];

    assign in_ready = in_ready_q;
    assign found    = found_q;
    assign N        = n_q;
    assign status   = status_q;
    assign err_pos  = err_pos_q;
    assign err_sign = err_sign_q;

    // Decoder FSM: residue, error search, correction, division, and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            found_q    <= 1'b0;
            n_q        <= '0;
            status_q   <= ST_CLEAN;
            err_pos_q  <= '0;
            err_sign_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        word_q     <= {1'b0, W};
                        sh_q       <= W;
                        r_q        <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        n_q        <= '0;
                        status_q   <= ST_CLEAN;
                        err_pos_q  <= '0;
                        err_sign_q <= 1'b0;
                        state_q    <= S_RESID;
                    end
                end
                S_RESID: begin
                    if (cnt_q == C_BITS'(W_BITS)) begin
                        if (r_q == '0) begin
                            sh_q    <= word_q[W_BITS-1:0];
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DIVIDE;
                        end else begin
                            idx_q   <= '0;
                            p_q     <= {{A_BITS{1'b0}}, 1'b1};
                            state_q <= S_SEARCH;
                        end
                    end else begin
                        r_q   <= mod_dbl(r_q, sh_q[W_BITS-1]);
                        sh_q  <= sh_q << 1;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SEARCH: begin
                    if ((r_q == p_q) && sub_ok) begin
                        cand_q  <= sub_w;
                        sign_q  <= 1'b1;
                        state_q <= S_CORR;
                    end else if ((r_q == (A_X - p_q)) && add_ok) begin
                        cand_q  <= add_w;
                        sign_q  <= 1'b0;
                        state_q <= S_CORR;
                    end else if (idx_q == P_BITS'(W_BITS - 1)) begin
                        n_q      <= '0;
                        status_q <= ST_UNCORR;
                        found_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        p_q   <= mod_dbl(p_q, 1'b0);
                    end
                end
                S_CORR: begin
                    word_q     <= cand_q;
                    sh_q       <= cand_q[W_BITS-1:0];
                    rem_q      <= '0;
                    cnt_q      <= '0;
                    status_q   <= ST_CORR;
                    err_pos_q  <= idx_q;
                    err_sign_q <= sign_q;
                    state_q    <= S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= mod_dbl(rem_q, sh_q[W_BITS-1]);
                    n_q   <= {n_q[N_BITS-1:0], ge_a(rem_q, sh_q[W_BITS-1])};
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_BITS'(W_BITS - 1)) begin
                        found_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        found_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec_an_decoder_seq.sv
// Bench for sec_an_decoder_seq: small configuration (A=23, 9-bit codewords)
// plus one word through the default 52-bit / A=311 configuration.
module tb_sec_an_decoder_seq;

    localparam int NB = 4;
    localparam int AB = 5;
    localparam int AV = 23;
    localparam int WB = NB + AB;
    localparam int PB = $clog2(WB);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WB-1:0] w_in;
    logic          found;
    logic          out_ready;
    logic [NB:0]   n_out;
    logic [1:0]    status;
    logic [PB-1:0] err_pos;
    logic          err_sign;

    logic          b_valid;
    logic          b_ready;
    logic [60:0]   b_w;
    logic          b_found;
    logic          b_out_ready;
    logic [52:0]   b_n;
    logic [1:0]    b_status;
    logic [5:0]    b_err_pos;
    logic          b_err_sign;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int w;
        int n;
        int st;
        int pos;
        int sgn;
        int lat;
    } vec_t;

    vec_t tbl[5];

    always #5 clk = ~clk;

    sec_an_decoder_seq #(.N_BITS(NB), .A_BITS(AB), .A(5'd23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .W(w_in),
        .found(found), .out_ready(out_ready), .N(n_out), .status(status),
        .err_pos(err_pos), .err_sign(err_sign)
    );

    sec_an_decoder_seq dut_big (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .W(b_w),
        .found(b_found), .out_ready(b_out_ready), .N(b_n), .status(b_status),
        .err_pos(b_err_pos), .err_sign(b_err_sign)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference decoder straight from the code's definition: residue by %,
    // quotient by /, error search over signed powers of two.
    function automatic vec_t model(input int w);
        vec_t v;
        int   r;
        v.w = w; v.n = 0; v.st = 2; v.pos = 0; v.sgn = 0; v.lat = 2 * WB + 1;
        r = w % AV;
        if (r == 0) begin
            v.st = 0;
            v.n  = w / AV;
        end else begin
            for (int i = 0; i < WB; i++) begin
                int pw;
                int p;
                pw = 1 << i;
                p  = pw % AV;
                if (r == p && w >= pw) begin
                    v.st = 1; v.n = (w - pw) / AV; v.pos = i; v.sgn = 1; v.lat = 2 * WB + i + 3;
                    break;
                end
                if (r == AV - p && w + pw <= (1 << WB) - 1) begin
                    v.st = 1; v.n = (w + pw) / AV; v.pos = i; v.sgn = 0; v.lat = 2 * WB + i + 3;
                    break;
                end
            end
        end
        return v;
    endfunction

    // Count edges after the accepting edge until found is seen (bounded).
    task automatic wait_found(output int lat, input bit noise);
        lat = 0;
        while (!found && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (noise) w_in = WB'($urandom);
        end
    endtask

    task automatic check_result(input string tag, input vec_t e, input int lat);
        chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
        chk({tag, ".N"}, 64'(n_out), 64'(e.n));
        chk({tag, ".status"}, 64'(status), 64'(e.st));
        chk({tag, ".err_pos"}, 64'(err_pos), 64'(e.pos));
        chk({tag, ".err_sign"}, 64'(err_sign), 64'(e.sgn));
    endtask

    // Full transaction: accept, noisy inputs while busy, hold result, release.
    task automatic run_word(input int w, input vec_t e, input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        w_in     = w[WB-1:0];
        @(posedge clk);
        @(negedge clk);
        w_in = WB'($urandom);
        wait_found(lat, 1'b1);
        in_valid = 1'b0;
        check_result(tag, e, lat);
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, ".found_held"}, 64'(found), 64'd1);
        chk({tag, ".busy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".found_drop"}, 64'(found), 64'd0);
        chk({tag, ".ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, ".N_kept"}, 64'(n_out), 64'(e.n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   w;
        vec_t e;

        tbl[0] = '{345, 15, 0, 0, 0, 19};
        tbl[1] = '{353, 15, 1, 3, 1, 24};
        tbl[2] = '{344, 15, 1, 0, 0, 21};
        tbl[3] = '{6, 0, 2, 0, 0, 19};
        tbl[4] = '{511, 0, 2, 0, 0, 19};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; w_in = '0;
        b_valid = 1'b0; b_out_ready = 1'b1; b_w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.found", 64'(found), 64'd0);
        chk("reset.N", 64'(n_out), 64'd0);
        chk("reset.status", 64'(status), 64'd0);
        chk("reset.err_pos", 64'(err_pos), 64'd0);
        chk("reset.err_sign", 64'(err_sign), 64'd0);
        rst = 1'b0;

        // Directed vectors from the specification.
        for (int i = 0; i < 5; i++) begin
            run_word(tbl[i].w, tbl[i], i, $sformatf("tbl%0d", i));
        end

        // Randomized codewords with optional single +/-2^i errors or raw noise.
        for (int k = 0; k < 40; k++) begin
            int q;
            int mode;
            int bi;
            q    = int'($urandom_range(0, 22));
            w    = AV * q;
            mode = int'($urandom_range(0, 3));
            bi   = int'($urandom_range(0, WB - 1));
            if (mode == 1 && w + (1 << bi) <= 511) w = w + (1 << bi);
            else if (mode == 2 && w >= (1 << bi)) w = w - (1 << bi);
            else if (mode == 3) w = int'($urandom_range(0, 511));
            e = model(w);
            run_word(w, e, int'($urandom_range(0, 3)), $sformatf("rnd%0d_w%0d", k, w));
        end

        // Reset in the middle of dividing a corrected word.
        @(negedge clk);
        in_valid = 1'b1; w_in = 9'd353;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        chk("midrst.found", 64'(found), 64'd0);
        chk("midrst.N", 64'(n_out), 64'd0);
        chk("midrst.status", 64'(status), 64'd0);
        chk("midrst.err_pos", 64'(err_pos), 64'd0);
        chk("midrst.err_sign", 64'(err_sign), 64'd0);
        run_word(345, tbl[0], 0, "after_rst");

        // Back-to-back: second word waits on in_valid while the first result is held.
        @(negedge clk);
        in_valid = 1'b1; w_in = 9'd344;
        @(posedge clk);
        @(negedge clk);
        w_in = 9'd353;
        wait_found(lat, 1'b0);
        check_result("b2b.first", tbl[2], lat);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b.hold%0d.found", c), 64'(found), 64'd1);
            chk($sformatf("b2b.hold%0d.in_ready", c), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b.release.found", 64'(found), 64'd0);
        chk("b2b.release.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_found(lat, 1'b0);
        check_result("b2b.second", tbl[1], lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b.end.in_ready", 64'(in_ready), 64'd1);

        // Default configuration: largest quotient, clean word.
        @(negedge clk);
        b_valid = 1'b1;
        b_w     = 61'(311) * ((61'(1) << 52) - 61'(1));
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        lat = 0;
        while (!b_found && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("big.latency", 64'(lat), 64'd123);
        chk("big.N", 64'(b_n), (64'd1 << 52) - 64'd1);
        chk("big.status", 64'(b_status), 64'd0);
        chk("big.err_pos", 64'(b_err_pos), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
